// File: rtl/muldiv_pkg.sv
// Shared types, constants and op decode for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned RD_W  = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGNED_OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

  // Per-operation control carried from accept through completion
  typedef struct packed {
    logic is_mul;
    logic hi_sel;
    logic neg;
  } op_ctrl_t;

  // {rs1 signed, rs2 signed} for each funct3
  function automatic logic [1:0] signed_ops(input logic [2:0] f3);
    logic [1:0] s;
    s = 2'b00;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 2'b11;
      F3_MULHSU:               s = 2'b10;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

  // neg_a/neg_b are the operand signs already qualified by signedness
  function automatic op_ctrl_t decode_op(input logic [2:0] f3, input logic neg_a,
                                         input logic neg_b);
    op_ctrl_t c;
    c.is_mul = ~f3[2];
    c.hi_sel = 1'b0;
    c.neg    = neg_a ^ neg_b;
    case (f3)
      F3_MUL:                       c.hi_sel = 1'b0;
      F3_MULH, F3_MULHSU, F3_MULHU: c.hi_sel = 1'b1;
      F3_DIV, F3_DIVU:              c.hi_sel = 1'b0;
      F3_REM: begin
        c.hi_sel = 1'b1;
        c.neg    = neg_a;
      end
      F3_REMU:                      c.hi_sel = 1'b1;
      default:                      c.hi_sel = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the muldiv sequencer.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [RD_W-1:0] rd_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [RD_W-1:0] rd_o;

  modport master (
    output start_i, flush_i, funct3_i, op_a_i, op_b_i, rd_i,
    input  stall_o, busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, op_a_i, op_b_i, rd_i,
    output stall_o, busy_o, valid_o, result_o, rd_o
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Shift-add multiply / restoring divide datapath with sign correction on magnitudes.
// MULDIV_FAST_MUL_EN adds a single-cycle product selected while loading.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  op_ctrl_t        ctrl,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] res_c
);

  logic [DW-1:0]   acc;
  logic [DW-1:0]   acc_next;
  logic [DW-1:0]   src;
  logic [DW-1:0]   full;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] half;
  logic [XLEN-1:0] diff;
  logic [XLEN:0]   hi_sum;
  logic [XLEN:0]   trial;
  logic            ge;

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    hi_sum = {1'b0, acc[DW-1:XLEN]} + {1'b0, opb};
    trial  = {acc[DW-1:XLEN], acc[XLEN-1]};
    ge     = trial >= {1'b0, opb};
    diff   = trial[XLEN-1:0] - opb;
    if (ctrl.is_mul) begin
      acc_next = acc[0] ? {hi_sum, acc[XLEN-1:1]} : {1'b0, acc[DW-1:1]};
    end else begin
      acc_next = {(ge ? diff : trial[XLEN-1:0]), acc[XLEN-2:0], ge};
    end
  end

  // Products negate across the full width; quotient/remainder negate per half
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    src = load ? DW'(a_mag) * DW'(b_mag) : acc_next;
`else
    src = acc_next;
`endif
    full  = (ctrl.is_mul && ctrl.neg) ? DW'(0) - src : src;
    half  = ctrl.hi_sel ? full[DW-1:XLEN] : full[XLEN-1:0];
    res_c = (!ctrl.is_mul && ctrl.neg) ? XLEN'(0) - half : half;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      opb <= '0;
    end else if (load) begin
      acc <= {XLEN'(0), a_mag};
      opb <= b_mag;
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, iteration counter, stall/flush and result registers.
// MULDIV_FAST_MUL_EN completes all MUL* ops in the accept cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  op_ctrl_t         ctrl_q;
  op_ctrl_t         dec_c;
  op_ctrl_t         ctrl_c;
  logic [RD_W-1:0]  rd_q;
  logic [RD_W-1:0]  rd_out_q;
  logic [XLEN-1:0]  result_q;
  logic             busy_q;
  logic             valid_q;

  logic [1:0]       sgn_c;
  logic             neg_a_c;
  logic             neg_b_c;
  logic [XLEN-1:0]  a_mag_c;
  logic [XLEN-1:0]  b_mag_c;
  logic [XLEN-1:0]  core_res_c;
  logic [XLEN-1:0]  short_res_c;
  logic             accept_c;
  logic             step_c;
  logic             div0_c;
  logic             ovf_c;
  logic             shortcut_c;

  // Operand decode and accept conditions
  always_comb begin
    sgn_c    = signed_ops(bus.funct3_i);
    neg_a_c  = sgn_c[1] & bus.op_a_i[XLEN-1];
    neg_b_c  = sgn_c[0] & bus.op_b_i[XLEN-1];
    a_mag_c  = neg_a_c ? XLEN'(0) - bus.op_a_i : bus.op_a_i;
    b_mag_c  = neg_b_c ? XLEN'(0) - bus.op_b_i : bus.op_b_i;
    dec_c    = decode_op(bus.funct3_i, neg_a_c, neg_b_c);
    ctrl_c   = (state == IDLE) ? dec_c : ctrl_q;
    accept_c = (state == IDLE) && bus.start_i && !bus.flush_i;
    step_c   = (state == CALC) && !bus.flush_i;
    div0_c   = bus.funct3_i[2] && (bus.op_b_i == '0);
    ovf_c    = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
               (bus.op_a_i == SIGNED_OVF_Q) && (bus.op_b_i == {XLEN{1'b1}});
`ifdef MULDIV_FAST_MUL_EN
    shortcut_c = div0_c || ovf_c || dec_c.is_mul;
`else
    shortcut_c = div0_c || ovf_c;
`endif
    if (div0_c) begin
      short_res_c = bus.funct3_i[1] ? bus.op_a_i : DIV_BY_ZERO_Q;
    end else if (ovf_c) begin
      short_res_c = bus.funct3_i[1] ? XLEN'(0) : SIGNED_OVF_Q;
    end else begin
      short_res_c = core_res_c;
    end
  end

  muldiv_iter_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_c),
    .step  (step_c),
    .ctrl  (ctrl_c),
    .a_mag (a_mag_c),
    .b_mag (b_mag_c),
    .res_c (core_res_c)
  );

  // FSM, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ctrl_q   <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            ctrl_q <= dec_c;
            rd_q   <= bus.rd_i;
            cnt    <= CNT_W'(XLEN - 1);
            busy_q <= 1'b1;
            if (shortcut_c) begin
              state    <= DONE;
              valid_q  <= 1'b1;
              result_q <= short_res_c;
              rd_out_q <= bus.rd_i;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == '0) begin
            state    <= DONE;
            valid_q  <= 1'b1;
            result_q <= core_res_c;
            rd_out_q <= rd_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving during DONE kills the completing instruction's write
  assign bus.stall_o  = rst_n && (accept_c || (state == CALC));
  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q && !bus.flush_i;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; honours MULDIV_FAST_MUL_EN latency.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, find its valid pulse and check latency, stall window, result and hold
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    int          stall_n;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        busy_v;
    logic        stall_v;
    lat = 0; stall_n = 0; res = '0; rdo = '0; busy_v = 1'b0; stall_v = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = f3; bus.op_a_i = a; bus.op_b_i = b; bus.rd_i = rd;
    #1;
    check({tag, "_stall_acc"}, 32'(bus.stall_o), 32'd1);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0; bus.op_a_i = 32'hdead_beef; bus.op_b_i = 32'h1234_5678; bus.rd_i = 5'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        lat = i; res = bus.result_o; rdo = bus.rd_o; busy_v = bus.busy_o; stall_v = bus.stall_o;
        break;
      end
      if (bus.stall_o) stall_n++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, res, exp_res);
    check({tag, "_rd"}, 32'(rdo), 32'(rd));
    check({tag, "_busy_done"}, 32'(busy_v), 32'd1);
    check({tag, "_stall_done"}, 32'(stall_v), 32'd0);
    check({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_lat - 1));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_hold"}, bus.result_o, exp_res);
    check({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = 3'd0;
    bus.op_a_i = '0; bus.op_b_i = '0; bus.rd_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_rd", 32'(bus.rd_o), 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, MUL_LAT);
    run_op("div_m20_3", F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFA, DIV_LAT);
    run_op("rem_m20_3", F3_REM, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFE, DIV_LAT);
    run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, MUL_LAT);
    run_op("divu_by0", F3_DIVU, 32'd123, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", F3_REMU, 32'd123, 32'd0, 5'd10, 32'd123, 1);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
    run_op("mulh_m3x5", F3_MULH, 32'hFFFF_FFFD, 32'd5, 5'd13, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mul_m3x5", F3_MUL, 32'hFFFF_FFFD, 32'd5, 5'd14, 32'hFFFF_FFF1, MUL_LAT);
    run_op("mulhsu_m1x2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd15, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu_2xmax", F3_MULHSU, 32'd2, 32'hFFFF_FFFF, 5'd16, 32'd1, MUL_LAT);

    // Flush on the 10th CALC cycle
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = F3_DIVU; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    bus.rd_i = 5'd20;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_busy_before", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 32'(bus.busy_o), 32'd0);
    check("flush_stall_after", 32'(bus.stall_o), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("flush_no_valid", 32'(pulses), 32'd0);
    check("flush_rd_kept", 32'(bus.rd_o), 32'd16);
    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, DIV_LAT);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = F3_DIVU; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd9;
    bus.rd_i = 5'd18;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_busy_before", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_stall", 32'(bus.stall_o), 32'd0);
    check("rstmid_busy", 32'(bus.busy_o), 32'd0);
    check("rstmid_valid", 32'(bus.valid_o), 32'd0);
    check("rstmid_result", bus.result_o, 32'd0);
    check("rstmid_rd", 32'(bus.rd_o), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("rstmid_no_valid", 32'(pulses), 32'd0);

    // start_i held through DONE must not start a new operation
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = F3_DIVU; bus.op_a_i = 32'd5; bus.op_b_i = 32'd0;
    bus.rd_i = 5'd19;
    @(posedge clk);
    #1 bus.rd_i = 5'd21;
    @(negedge clk);
    check("done_start_valid", 32'(bus.valid_o), 32'd1);
    check("done_start_result", bus.result_o, 32'hFFFF_FFFF);
    check("done_start_rd", 32'(bus.rd_o), 32'd19);
    check("done_start_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check("done_start_busy", 32'(bus.busy_o), 32'd0);
    check("done_start_no_valid", 32'(bus.valid_o), 32'd0);
    check("done_start_rd_hold", 32'(bus.rd_o), 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
